// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: MEM-stage pipeline controls and dcache request/response bundle
interface mem_stage_ctrl_if;
  logic        memcuDRE;
  logic        memcuDWE;
  logic [31:0] memOutput_Port;
  logic [31:0] memrdat2;
  logic        memflush;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        memstall;
  logic [31:0] memload;
  logic        mem_err;
  logic [7:0]  wait_cnt;
  modport slave (
    input  memcuDRE, memcuDWE, memOutput_Port, memrdat2, memflush, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, memstall, memload, mem_err, wait_cnt
  );
  modport master (
    output memcuDRE, memcuDWE, memOutput_Port, memrdat2, memflush, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, memstall, memload, mem_err, wait_cnt
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: runs the data-memory handshake for the MEM stage and stalls the pipeline until it completes
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64
) (
  input logic             CLK,
  input logic             RST,
  mem_stage_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q, state_d;
  logic        ren_q, ren_d, wen_q, wen_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, store_q, store_d, load_q, load_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        req;
  assign req     = (bus.memcuDRE | bus.memcuDWE) & ~bus.memflush;
  assign cnt_inc = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
  // state and registered request/response outputs; reset abandons any access in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      load_q  <= load_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: launch on req in IDLE, wait for dhit in ACCESS, one release cycle in DONE
  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    store_d = store_q;
    load_d  = load_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && req) begin
      state_d = ACCESS;
      addr_d  = bus.memOutput_Port;
      store_d = bus.memrdat2;
      wen_d   = bus.memcuDWE;
      ren_d   = bus.memcuDRE & ~bus.memcuDWE;
      cnt_d   = '0;
      err_d   = err_q | (bus.memcuDRE & bus.memcuDWE);
    end else if (state_q == ACCESS && bus.dhit) begin
      state_d = DONE;
      load_d  = ren_q ? bus.dmemload : load_q;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
    end else if (state_q == ACCESS) begin
      cnt_d   = cnt_inc;
      err_d   = err_q | (32'(cnt_inc) == TIMEOUT);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  assign bus.memstall  = (state_q == IDLE && req) || state_q == ACCESS;
  assign bus.dmemREN   = ren_q;
  assign bus.dmemWEN   = wen_q;
  assign bus.dmemaddr  = addr_q;
  assign bus.dmemstore = store_q;
  assign bus.memload   = load_q;
  assign bus.mem_err   = err_q;
  assign bus.wait_cnt  = cnt_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and randomized transaction-level checking of mem_stage_ctrl
module tb_mem_stage_ctrl;
  localparam int TO = 4;
  logic CLK = 1'b0;
  logic RST;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_load;
  logic        exp_err;
  int          exp_wcnt;
  mem_stage_ctrl_if bus();
  mem_stage_ctrl #(.TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag);
    chk({tag, ".memload"}, bus.memload, exp_load);
    chk({tag, ".mem_err"}, 32'(bus.mem_err), 32'(exp_err));
    chk({tag, ".wait_cnt"}, 32'(bus.wait_cnt), 32'(exp_wcnt));
  endtask
  task automatic model_reset();
    exp_load = '0;
    exp_err  = 1'b0;
    exp_wcnt = 0;
  endtask
  task automatic idle_inputs();
    bus.memcuDRE = 0; bus.memcuDWE = 0; bus.memflush = 0; bus.dhit = 0;
    bus.memOutput_Port = '0; bus.memrdat2 = '0; bus.dmemload = '0;
  endtask
  // one MEM-stage instruction: issue cycle, waits+1 access cycles, one release cycle
  task automatic op(input logic dre, input logic dwe, input logic fl, input logic [31:0] a,
                    input logic [31:0] d, input int waits, input logic [31:0] ld);
    logic req;
    req = (dre | dwe) & ~fl;
    bus.memcuDRE = dre; bus.memcuDWE = dwe; bus.memflush = fl;
    bus.memOutput_Port = a; bus.memrdat2 = d; bus.dhit = 0; bus.dmemload = $urandom;
    @(negedge CLK);
    chk("issue.memstall", 32'(bus.memstall), 32'(req));
    chk("issue.ren", 32'(bus.dmemREN), 0);
    chk("issue.wen", 32'(bus.dmemWEN), 0);
    chk_state("issue");
    @(posedge CLK); #1;
    if (!req) return;
    exp_wcnt = 0;
    if (dre & dwe) exp_err = 1'b1;
    for (int k = 0; k <= waits; k++) begin
      bus.dhit = (k == waits);
      bus.dmemload = (k == waits) ? ld : $urandom;
      bus.memcuDRE = 1'($urandom); bus.memcuDWE = 1'($urandom); bus.memflush = 1'($urandom);
      bus.memOutput_Port = $urandom; bus.memrdat2 = $urandom;
      @(negedge CLK);
      chk("acc.memstall", 32'(bus.memstall), 1);
      chk("acc.ren", 32'(bus.dmemREN), 32'(dre & ~dwe));
      chk("acc.wen", 32'(bus.dmemWEN), 32'(dwe));
      chk("acc.addr", bus.dmemaddr, a);
      chk("acc.store", bus.dmemstore, d);
      chk_state("acc");
      @(posedge CLK); #1;
      if (k < waits) begin
        if (exp_wcnt < 255) exp_wcnt++;
        if (exp_wcnt == TO) exp_err = 1'b1;
      end else if (dre & ~dwe) exp_load = ld;
    end
    bus.memcuDRE = dre; bus.memcuDWE = dwe; bus.memflush = 0; bus.dhit = 0;
    bus.memOutput_Port = a; bus.memrdat2 = d;
    @(negedge CLK);
    chk("done.memstall", 32'(bus.memstall), 0);
    chk("done.ren", 32'(bus.dmemREN), 0);
    chk("done.wen", 32'(bus.dmemWEN), 0);
    chk_state("done");
    @(posedge CLK); #1;
  endtask
  initial begin
    idle_inputs();
    RST = 1;
    model_reset();
    @(negedge CLK);
    chk("rst.memstall", 32'(bus.memstall), 0);
    chk("rst.ren", 32'(bus.dmemREN), 0);
    chk("rst.wen", 32'(bus.dmemWEN), 0);
    chk("rst.addr", bus.dmemaddr, 0);
    chk("rst.store", bus.dmemstore, 0);
    chk_state("rst");
    @(posedge CLK); #1;
    RST = 0;
    op(1, 0, 0, 32'h40, 32'h0, 0, 32'hDEAD_BEEF);
    op(0, 1, 0, 32'h80, 32'h1234_5678, 3, 32'h5555_5555);
    op(1, 0, 1, 32'hC0, 32'h0, 0, 32'h0);
    op(0, 0, 0, 32'hC4, 32'h0, 0, 32'h0);
    op(1, 0, 0, 32'h100, 32'h0, 2, 32'hCAFE_F00D);
    op(1, 0, 0, 32'h104, 32'h0, 6, 32'h0BAD_F00D);
    op(1, 1, 0, 32'h108, 32'hAAAA_0000, 1, 32'h7777_7777);
    op(1, 0, 0, 32'h200, 32'h0, 0, 32'h1111_1111);
    op(1, 0, 0, 32'h204, 32'h0, 0, 32'h2222_2222);
    op(0, 1, 0, 32'h300, 32'hFFFF_0000, 300, 32'h0);
    bus.memcuDRE = 1; bus.memcuDWE = 0; bus.memflush = 0; bus.dhit = 0;
    bus.memOutput_Port = 32'h400; bus.memrdat2 = 32'h0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstmid.pre_ren", 32'(bus.dmemREN), 1);
    bus.memcuDRE = 0;
    RST = 1;
    #1;
    model_reset();
    chk("rstmid.ren", 32'(bus.dmemREN), 0);
    chk("rstmid.memstall", 32'(bus.memstall), 0);
    chk_state("rstmid");
    @(posedge CLK); #1;
    RST = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstrel.ren", 32'(bus.dmemREN), 0);
    chk("rstrel.wen", 32'(bus.dmemWEN), 0);
    chk("rstrel.memstall", 32'(bus.memstall), 0);
    @(posedge CLK); #1;
    for (int i = 0; i < 40; i++) begin
      logic dre, dwe, fl;
      dre = 1'($urandom);
      dwe = ($urandom_range(0, 9) == 0) ? 1'b1 : (dre ? 1'b0 : 1'($urandom));
      fl  = ($urandom_range(0, 4) == 0);
      op(dre, dwe, fl, $urandom, $urandom, $urandom_range(0, 6), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
